// File: rtl/audio_tone_pkg.sv
// ---------------------------------------------------------------------------
// audio_tone_pkg
// Shared types and constants for the stereo test-tone generator:
//   waveform_t    - waveform select encoding (matches the 2-bit waveform input)
//   tone_state_t  - mute/ramp state machine encoding
//   LFSR_SEED/TAPS- dither LFSR constants (used only with AUDIO_TONE_DITHER_EN)
//   step_toward   - move a gain value one step toward a target
// ---------------------------------------------------------------------------
package audio_tone_pkg;

    typedef enum logic [1:0] {
        SQUARE   = 2'b00,
        SAWTOOTH = 2'b01,
        TRIANGLE = 2'b10,
        SILENCE  = 2'b11
    } waveform_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RAMP_UP   = 2'b01,
        RUN       = 2'b10,
        RAMP_DOWN = 2'b11
    } tone_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/audio_tone_generator_if.sv
// ---------------------------------------------------------------------------
// audio_tone_generator_if
// Control and sample bus of the tone generator.
//   enable            - 1 = play, 0 = fade out and mute
//   waveform          - 00 square, 01 sawtooth, 10 triangle, 11 silence
//   amplitude         - target gain 0..255
//   phase_inc         - per-channel phase increment, [0] left, [1] right
//   audio_sample_word - signed samples, [0] left, [1] right
//   active            - generator is in RUN
//   ramp_busy         - gain is ramping up or down
// master: the controller/consumer side; slave: the generator itself.
// ---------------------------------------------------------------------------
interface audio_tone_generator_if #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int PHASE_WIDTH     = 16
);
    logic                                  enable;
    logic [1:0]                            waveform;
    logic [7:0]                            amplitude;
    logic [1:0][PHASE_WIDTH-1:0]           phase_inc;
    logic [1:0][AUDIO_BIT_WIDTH-1:0]       audio_sample_word;
    logic                                  active;
    logic                                  ramp_busy;

    modport master (
        output enable, waveform, amplitude, phase_inc,
        input  audio_sample_word, active, ramp_busy
    );

    modport slave (
        input  enable, waveform, amplitude, phase_inc,
        output audio_sample_word, active, ramp_busy
    );
endinterface

// File: rtl/audio_tone_shaper.sv
// ---------------------------------------------------------------------------
// audio_tone_shaper
// Combinational waveform shaper: turns a phase accumulator value into a raw
// full-scale signed sample.
//   phase_i    in  PHASE_WIDTH       phase accumulator value
//   waveform_i in  waveform_t        selected waveform
//   raw_o      out AUDIO_BIT_WIDTH   signed raw sample
// ---------------------------------------------------------------------------
module audio_tone_shaper
    import audio_tone_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int PHASE_WIDTH     = 16
) (
    input  logic [PHASE_WIDTH-1:0]            phase_i,
    input  waveform_t                         waveform_i,
    output logic signed [AUDIO_BIT_WIDTH-1:0] raw_o
);
    localparam int W = AUDIO_BIT_WIDTH;
    localparam logic signed [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    logic [W-1:0] p;
    logic [W-2:0] fold;

    assign p = phase_i[PHASE_WIDTH-1 -: W];

    always_comb begin
        // Second half of the cycle mirrors the first, giving a symmetric ramp.
        fold  = p[W-1] ? ~p[W-2:0] : p[W-2:0];
        raw_o = '0;
        case (waveform_i)
            SQUARE:   raw_o = p[W-1] ? -MAX_POS : MAX_POS;
            SAWTOOTH: raw_o = {~p[W-1], p[W-2:0]};
            // (fold << 1) - 2^(W-1) is the same as inverting the top bit.
            TRIANGLE: raw_o = {~fold[W-2], fold[W-3:0], 1'b0};
            default:  raw_o = '0;
        endcase
    end
endmodule

// File: rtl/audio_tone_generator.sv
// ---------------------------------------------------------------------------
// audio_tone_generator
// Stereo test-tone source. Two phase accumulators feed per-channel shapers;
// a shared gain, faded by a mute/ramp FSM, scales both channels so that
// starting and stopping the tone never clicks.
//
// Ports:
//   clk_audio  in   sample clock, one stereo sample per edge
//   reset      in   synchronous, active-high
//   bus        slave modport of audio_tone_generator_if
//
// Optional build macro AUDIO_TONE_DITHER_EN: adds a 16-bit LFSR that applies
// -1/0/+1 LSB of dither per channel outside IDLE, saturating to +/-M.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | muted, phase held at 0, outputs forced to 0
// RAMP_UP   | gain stepping toward amplitude
// RUN       | playing, gain tracks amplitude by +/-1 per tick
// RAMP_DOWN | gain stepping toward 0, then IDLE
// ---------------------------------------------------------------------------
module audio_tone_generator
    import audio_tone_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int PHASE_WIDTH     = 16,
    parameter int RAMP_SHIFT      = 0
) (
    input  logic                   clk_audio,
    input  logic                   reset,
    audio_tone_generator_if.slave  bus
);
    localparam int W  = AUDIO_BIT_WIDTH;
    localparam int CW = (RAMP_SHIFT > 0) ? RAMP_SHIFT : 1;

    tone_state_t                  state_q, state_d;
    logic [7:0]                   gain_q, gain_d;
    logic [CW-1:0]                ramp_cnt_q, ramp_cnt_d;
    logic [1:0][PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [1:0][W-1:0]            sample_q, sample_d;
    logic                         tick;

    assign tick = (RAMP_SHIFT == 0) ? 1'b1 : (&ramp_cnt_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            state_q    <= IDLE;
            gain_q     <= '0;
            ramp_cnt_q <= '0;
            phase_q    <= '0;
            sample_q   <= '0;
        end else begin
            state_q    <= state_d;
            gain_q     <= gain_d;
            ramp_cnt_q <= ramp_cnt_d;
            phase_q    <= phase_d;
            sample_q   <= sample_d;
        end
    end

    // ---------------- next state / gain ----------------
    // The edge that changes direction only changes state; gain moves from
    // the following tick onward.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (!bus.enable) begin
                    state_d = RAMP_DOWN;
                end else begin
                    if (tick) gain_d = step_toward(gain_q, bus.amplitude);
                    if (gain_d == bus.amplitude) state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d = RAMP_DOWN;
                end else if (tick) begin
                    gain_d = step_toward(gain_q, bus.amplitude);
                end
            end
            RAMP_DOWN: begin
                if (bus.enable) begin
                    state_d = RAMP_UP;
                end else begin
                    if (tick && (gain_q != 8'd0)) gain_d = gain_q - 8'd1;
                    if (gain_d == 8'd0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramp_cnt_d = ramp_cnt_q + 1'b1;
        if ((state_d != state_q) || (RAMP_SHIFT == 0)) ramp_cnt_d = '0;
    end

    always_comb begin
        phase_d = '0;
        for (int c = 0; c < 2; c++) begin
            if ((state_q != IDLE) && (state_d != IDLE)) begin
                phase_d[c] = phase_q[c] + bus.phase_inc[c];
            end
        end
    end

`ifdef AUDIO_TONE_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_audio) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end
`endif

    // ---------------- per-channel datapath ----------------
    for (genvar c = 0; c < 2; c++) begin : g_chan
        logic signed [W-1:0] raw;
        logic signed [W+8:0] prod;
        logic signed [W-1:0] scaled;
        logic signed [W-1:0] shaped;

        audio_tone_shaper #(
            .AUDIO_BIT_WIDTH (AUDIO_BIT_WIDTH),
            .PHASE_WIDTH     (PHASE_WIDTH)
        ) u_shaper (
            .phase_i    (phase_q[c]),
            .waveform_i (waveform_t'(bus.waveform)),
            .raw_o      (raw)
        );

        // Gain is unsigned; a zero-extended signed operand keeps the multiply signed.
        assign prod   = raw * $signed({1'b0, gain_q});
        assign scaled = W'(prod >>> 8);

`ifdef AUDIO_TONE_DITHER_EN
        localparam logic signed [W:0] SAT_POS = {2'b00, {(W-1){1'b1}}};
        logic signed [1:0] dstep;
        logic signed [W:0] dsum;

        assign dstep = $signed({1'b0, lfsr_q[2*c]}) - $signed({1'b0, lfsr_q[2*c+1]});
        assign dsum  = $signed({scaled[W-1], scaled}) + $signed({{(W-1){dstep[1]}}, dstep});

        always_comb begin
            shaped = dsum[W-1:0];
            if (dsum > SAT_POS)       shaped = SAT_POS[W-1:0];
            else if (dsum < -SAT_POS) shaped = W'(-SAT_POS);
        end
`else
        assign shaped = scaled;
`endif

        assign sample_d[c] = (state_q == IDLE) ? '0 : shaped;
    end

    assign bus.audio_sample_word = sample_q;
    assign bus.active            = (state_q == RUN);
    assign bus.ramp_busy         = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule
